// File: rtl/lcd_char_feeder_pkg.sv
// rtl/lcd_char_feeder_pkg.sv - shared state enumeration and FIFO entry layout
// Purpose: types and constants common to lcd_char_feeder and its FIFO.
// Contents: state_t (transfer FSM states), ENTRY_* layout of the 9-bit
//           {rs, data} FIFO entry, make_entry() packing helper.
package lcd_char_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_PULSE,
        RD_END,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam int ENTRY_DATA_W = 8;
    localparam int ENTRY_RS_BIT = 8;
    localparam int ENTRY_W      = 9;

    // rs=1 selects the data register, so a command byte carries rs=0.
    function automatic logic [ENTRY_W-1:0] make_entry(input logic       cmd,
                                                      input logic [7:0] data);
        return {~cmd, data};
    endfunction

endpackage

// File: rtl/lcd_char_feeder_fifo.sv
// rtl/lcd_char_feeder_fifo.sv - synchronous FIFO holding {rs, data} entries
// Purpose: DEPTH-entry FIFO with full/empty flags; read data is the head entry.
// Ports: i_clk, i_rst (async, active-high), i_push/i_data write side,
//        i_pop/o_data read side, o_full, o_empty.
module lcd_feeder_fifo
    import lcd_char_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_pop;
    logic               w_push;

    // Extra MSB on each pointer distinguishes full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    // A push while full is accepted if the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/lcd_char_feeder.sv
// rtl/lcd_char_feeder.sv - feeds queued bytes to an HD44780-style LCD bus
// Purpose: buffers CPU bytes, polls the LCD busy flag, then writes each entry.
// Ports: clk, out_rst (async, active-high); cpu_data/cpu_wr/cpu_cmd push side;
//        full, idle, overflow, busy_err status; lcd_bus (inout), lcd_enable,
//        lcd_rnw, lcd_rs LCD side.
module lcd_char_feeder
    import lcd_char_feeder_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int EN_HIGH   = 2,
    parameter int MAX_POLLS = 16
) (
    input  logic       clk,
    input  logic       out_rst,
    input  logic [7:0] cpu_data,
    input  logic       cpu_wr,
    input  logic       cpu_cmd,
    output logic       full,
    output logic       idle,
    output logic       overflow,
    output logic       busy_err,
    inout  wire  [7:0] lcd_bus,
    output logic       lcd_enable,
    output logic       lcd_rnw,
    output logic       lcd_rs
);

    localparam int          PW        = $clog2(MAX_POLLS + 1);
    localparam logic [3:0]  EN_LAST   = 4'(EN_HIGH - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_abandon;
    logic               w_pulse_last;
    logic [3:0]         r_cnt;
    logic [PW-1:0]      r_polls;
    logic               r_busy;
    logic               r_overflow;
    logic               r_busy_err;
    logic               r_enable;
    logic               r_rnw;
    logic               r_rs;
    logic               r_bus_oe;
    logic [7:0]         r_bus_out;
    logic               w_enable;
    logic               w_rnw;
    logic               w_rs;
    logic               w_bus_oe;
    logic [7:0]         w_bus_out;

    lcd_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst   (out_rst),
        .i_push  (cpu_wr),
        .i_data  (make_entry(cpu_cmd, cpu_data)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pulse_last = (r_cnt == EN_LAST);
    assign w_abandon    = (r_state == RD_END) && r_busy && (r_polls == POLL_LAST);
    assign w_pop        = (r_state == WR_HOLD) || w_abandon;

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (!w_empty) w_next = RD_SETUP;
            RD_SETUP: w_next = RD_PULSE;
            RD_PULSE: if (w_pulse_last) w_next = RD_END;
            RD_END: begin
                if (!r_busy)        w_next = WR_SETUP;
                else if (w_abandon) w_next = IDLE;
                else                w_next = RD_SETUP;
            end
            WR_SETUP: w_next = WR_PULSE;
            WR_PULSE: if (w_pulse_last) w_next = WR_HOLD;
            WR_HOLD:  w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every LCD
    // pin changes on the clock edge that enters the corresponding state.
    always_comb begin
        w_enable  = 1'b0;
        w_rnw     = 1'b1;
        w_rs      = 1'b0;
        w_bus_oe  = 1'b0;
        w_bus_out = r_bus_out;
        case (w_next)
            RD_PULSE: w_enable = 1'b1;
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                w_enable  = (w_next == WR_PULSE);
                w_rnw     = 1'b0;
                w_rs      = w_head[ENTRY_RS_BIT];
                w_bus_oe  = 1'b1;
                w_bus_out = w_head[ENTRY_DATA_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            r_enable  <= 1'b0;
            r_rnw     <= 1'b1;
            r_rs      <= 1'b0;
            r_bus_oe  <= 1'b0;
            r_bus_out <= '0;
        end else begin
            r_enable  <= w_enable;
            r_rnw     <= w_rnw;
            r_rs      <= w_rs;
            r_bus_oe  <= w_bus_oe;
            r_bus_out <= w_bus_out;
        end
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            r_cnt      <= '0;
            r_polls    <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_busy_err <= 1'b0;
        end else begin
            if ((r_state == RD_PULSE || r_state == WR_PULSE) && !w_pulse_last)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            // Busy flag is taken in the final enable-high cycle of a read.
            if (r_state == RD_PULSE && w_pulse_last)
                r_busy <= lcd_bus[7];
            if (r_state == WR_HOLD || w_abandon)
                r_polls <= '0;
            else if (r_state == RD_END && r_busy)
                r_polls <= r_polls + 1'b1;
            if (cpu_wr && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (w_abandon)
                r_busy_err <= 1'b1;
        end
    end

    assign lcd_bus    = r_bus_oe ? r_bus_out : 8'bz;
    assign lcd_enable = r_enable;
    assign lcd_rnw    = r_rnw;
    assign lcd_rs     = r_rs;
    assign full       = w_full;
    assign idle       = w_empty && (r_state == IDLE);
    assign overflow   = r_overflow;
    assign busy_err   = r_busy_err;

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb/tb_lcd_char_feeder.sv - directed self-checking bench for lcd_char_feeder
module tb_lcd_char_feeder;

    localparam int DEPTH     = 8;
    localparam int EN_HIGH   = 2;
    localparam int MAX_POLLS = 16;

    logic       clk = 1'b0;
    logic       out_rst = 1'b1;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_wr = 1'b0;
    logic       cpu_cmd = 1'b0;
    wire        full;
    wire        idle;
    wire        overflow;
    wire        busy_err;
    wire  [7:0] lcd_bus;
    wire        lcd_enable;
    wire        lcd_rnw;
    wire        lcd_rs;

    int n_cmp = 0;
    int n_err = 0;

    // Display model state
    int         reads = 0;
    int         rd_base = 0;
    int         busy_n = 0;
    bit         busy_forever = 1'b0;
    bit         probe = 1'b0;
    logic [7:0] status;
    logic [8:0] wq[$];
    int         en_rises = 0;
    int         viol = 0;
    int         bad_width = 0;
    int         unstable = 0;
    int         run = 0;
    logic       prev_en = 1'b0;
    logic       prev_rnw = 1'b1;
    logic       prev_rs = 1'b0;
    logic       rnw_l = 1'b1;
    logic       rs_l = 1'b0;
    logic [7:0] bus_l = 8'h00;

    lcd_char_feeder #(.DEPTH(DEPTH), .EN_HIGH(EN_HIGH), .MAX_POLLS(MAX_POLLS)) dut (
        .clk        (clk),
        .out_rst    (out_rst),
        .cpu_data   (cpu_data),
        .cpu_wr     (cpu_wr),
        .cpu_cmd    (cpu_cmd),
        .full       (full),
        .idle       (idle),
        .overflow   (overflow),
        .busy_err   (busy_err),
        .lcd_bus    (lcd_bus),
        .lcd_enable (lcd_enable),
        .lcd_rnw    (lcd_rnw),
        .lcd_rs     (lcd_rs)
    );

    always #5 clk = ~clk;

    assign status  = (busy_forever || ((reads - rd_base) < busy_n)) ? 8'h80 : 8'h00;
    assign lcd_bus = probe ? 8'h5A : ((lcd_rnw && lcd_enable) ? status : 8'bz);

    always @(negedge clk) begin
        if (((lcd_rnw !== prev_rnw) || (lcd_rs !== prev_rs)) &&
            (lcd_enable || prev_en) && !out_rst)
            viol++;
        if (lcd_enable && !prev_en) begin
            en_rises++;
            run   = 1;
            bus_l = lcd_bus;
            rnw_l = lcd_rnw;
            rs_l  = lcd_rs;
        end else if (lcd_enable) begin
            run++;
            if (!rnw_l && (lcd_bus !== bus_l)) unstable++;
        end else if (prev_en) begin
            if (run != EN_HIGH) bad_width++;
            if (rnw_l) reads++;
            else       wq.push_back({rs_l, bus_l});
        end
        prev_en  = lcd_enable;
        prev_rnw = lcd_rnw;
        prev_rs  = lcd_rs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic cmd, input logic [7:0] data);
        cpu_cmd  = cmd;
        cpu_data = data;
        cpu_wr   = 1'b1;
        @(posedge clk);
        #1;
        cpu_wr   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (!idle && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    task automatic apply_reset();
        out_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_rst = 1'b0;
    endtask

    task automatic check_bus_released(input string tag);
        probe = 1'b1;
        #1;
        check(tag, {24'd0, lcd_bus}, 32'h5A);
        probe = 1'b0;
    endtask

    initial begin
        int cyc;
        int wb;
        int rb;
        int eb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", {31'd0, lcd_enable}, 32'd0);
        check("rst_rnw", {31'd0, lcd_rnw}, 32'd1);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy_err", {31'd0, busy_err}, 32'd0);
        check_bus_released("rst_bus_z");
        @(posedge clk);
        #1;
        out_rst = 1'b0;

        // 'H' with the display busy for the first status read
        busy_n = 1; rd_base = reads; wb = wq.size(); rb = reads;
        push(1'b0, 8'h48);
        wait_idle(200, cyc);
        check("h_reads", reads - rb, 32'd2);
        check("h_writes", wq.size() - wb, 32'd1);
        check("h_entry", {23'd0, wq[wb]}, {23'd0, 9'h148});

        // Command 0x01 with a ready display: rs=0, minimum cost
        busy_n = 0; rd_base = reads; wb = wq.size(); rb = reads;
        push(1'b1, 8'h01);
        wait_idle(200, cyc);
        check("cmd_cycles", cyc, 2 * EN_HIGH + 5);
        check("cmd_reads", reads - rb, 32'd1);
        check("cmd_writes", wq.size() - wb, 32'd1);
        check("cmd_entry", {23'd0, wq[wb]}, {23'd0, 9'h001});

        // "AB\n" back-to-back
        wb = wq.size(); rb = reads;
        push(1'b0, 8'h41);
        push(1'b0, 8'h42);
        push(1'b0, 8'h0A);
        wait_idle(300, cyc);
        check("abn_reads", reads - rb, 32'd3);
        check("abn_writes", wq.size() - wb, 32'd3);
        check("abn_w0", {23'd0, wq[wb]}, {23'd0, 9'h141});
        check("abn_w1", {23'd0, wq[wb + 1]}, {23'd0, 9'h142});
        check("abn_w2", {23'd0, wq[wb + 2]}, {23'd0, 9'h10A});

        // Display busy forever: entry abandoned after MAX_POLLS reads
        busy_forever = 1'b1; wb = wq.size(); rb = reads;
        push(1'b0, 8'h5B);
        wait_idle(2000, cyc);
        check("poll_reads", reads - rb, MAX_POLLS);
        check("poll_busy_err", {31'd0, busy_err}, 32'd1);
        check("poll_writes", wq.size() - wb, 32'd0);
        apply_reset();
        #1;
        check("poll_busy_err_clr", {31'd0, busy_err}, 32'd0);

        // Nine pushes into an eight-deep FIFO while the display is busy
        wb = wq.size();
        for (int i = 0; i < 9; i++) begin
            push(1'b0, 8'h41 + 8'(i));
            if (i == 7) begin
                check("ovf_full_after8", {31'd0, full}, 32'd1);
                check("ovf_none_after8", {31'd0, overflow}, 32'd0);
            end
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        busy_forever = 1'b0; busy_n = 0; rd_base = reads;
        wait_idle(2000, cyc);
        check("ovf_writes", wq.size() - wb, 32'd8);
        for (int i = 0; i < 8; i++)
            if (wb + i < wq.size())
                check("ovf_entry", {23'd0, wq[wb + i]}, {23'd0, 9'h141 + 9'(i)});
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("en_width", bad_width, 32'd0);
        check("rnw_rs_stable", viol, 32'd0);
        check("wr_bus_stable", unstable, 32'd0);

        // Reset during the write enable pulse
        push(1'b0, 8'h25);
        cyc = 0;
        while (!(lcd_enable && !lcd_rnw) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_wr_pulse_seen", {31'd0, (lcd_enable && !lcd_rnw)}, 32'd1);
        #2;
        out_rst = 1'b1;
        #1;
        check("mid_enable", {31'd0, lcd_enable}, 32'd0);
        check("mid_rnw", {31'd0, lcd_rnw}, 32'd1);
        check("mid_idle", {31'd0, idle}, 32'd1);
        check("mid_overflow_clr", {31'd0, overflow}, 32'd0);
        check_bus_released("mid_bus_z");
        @(posedge clk);
        #1;
        out_rst = 1'b0;
        eb = en_rises;
        repeat (40) @(posedge clk);
        #1;
        check("mid_no_pulses", en_rises - eb, 32'd0);
        check("mid_idle_after", {31'd0, idle}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
